data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the CPU load/store port: word-organised data RAM plus one MMIO GPIO word.
//  Accepts a request/ready handshake and applies RV32I byte/half/word sizing (funct3).
//  Performs byte-lane steering and write byte-enables, and sign/zero-extends loads.
//  Sits between the CPU data port and the board GPIO pins; instruction fetch is out of scope.
// PARAMETERS
//  DEPTH_WORDS   1024    RAM depth in 32-bit words (index = RAM_ADDR)
//  GPIO_WORD     10'h3FF word index decoded as GPIO register instead of RAM
//  SYNC_STAGES   2       synchroniser flops on GPIO_IN
// PORTS
//  CLK             in   1   system clock, rising edge
//  RST_N           in   1   asynchronous, active-low reset
//  RAM_REQ         in   1   request valid; CPU holds it and all request fields stable until RAM_READY
//  RAM_WRITE_ENABLE in  1   1 = store, 0 = load
//  RAM_ADDR        in   10  word index
//  RAM_BYTE_OFF    in   2   byte offset within the word
//  RAM_FUNCT3      in   3   size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU (stores use 0/1/2 only)
//  RAM_WRITE_DATA  in   32  store data, LSB-aligned
//  RAM_READ_DATA   out  32  extended load result, valid while RAM_READY=1
//  RAM_READY       out  1   one-cycle completion pulse
//  RAM_ERR         out  1   qualifies RAM_READY: misaligned or illegal funct3
//  GPIO_IN         in   32  asynchronous board inputs
//  GPIO            out  32  GPIO output register
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE; RAM_READ_DATA=0, RAM_READY=0, RAM_ERR=0, GPIO=0,
//   synchroniser flops=0. RAM contents are not reset.
//  FSM: IDLE, RD_WAIT, RESP.
//   IDLE, RAM_REQ=1 -> request accepted at that edge.
//   IDLE + legal store: byte-enabled write commits on the accept edge; next state RESP.
//   IDLE + legal load: RAM read is registered; next state RD_WAIT.
//   IDLE + error: no write, no read; next state RESP with RAM_ERR=1.
//   RD_WAIT -> RESP: latch the extended data into RAM_READ_DATA.
//   RESP: RAM_READY=1 for exactly this cycle, then IDLE.
//  Latency: store and error, READY 1 cycle after accept. Load, READY 2 cycles after accept.
//   No new request is accepted while in RD_WAIT or RESP.
//   Back-to-back: a REQ still high in the cycle after RESP is accepted as a new request.
//  Alignment: H/HU require BYTE_OFF[0]=0; W requires BYTE_OFF=0.
//   funct3 of 3, 6 or 7 is illegal; a store with funct3>2 is illegal.
//  Store lanes:
//   SB writes byte lane BYTE_OFF with WRITE_DATA[7:0].
//   SH writes lanes {OFF+1,OFF} with WRITE_DATA[15:0].
//   SW writes all four lanes.
//  Load extract: select the byte/half at BYTE_OFF; B/H sign-extend from the top bit; BU/HU zero-extend.
//  GPIO word:
//   A store updates only the addressed byte lanes of GPIO, taking effect at the accept edge.
//   A load returns the synchronised GPIO_IN (SYNC_STAGES flops), lane-extracted like RAM.
//   A RAM access never touches GPIO, and vice versa.
//  RAM_READ_DATA holds its last value outside RESP. For stores and errors it is 0 in RESP.
//  Reset mid-operation: a store already accepted is committed; a pending load is dropped.
//   No READY is issued after reset release.
// STRUCTURE
//  Package risc32i_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU),
//   GPIO_WORD default, and the FSM state encoding (IDLE/RD_WAIT/RESP).
//  Sub-module mem_lane_align (combinational):
//   inputs funct3, byte offset, store data and raw read word;
//   outputs 4-bit byte enable, lane-shifted write word, extended load word, misalign flag.
//  Top: FSM, RAM array (inferred with byte enables), GPIO register, synchroniser.
// TESTING
//  SW 0xDEADBEEF @word 5, then LW @5 -> READY 1 cycle after store accept, ERR=0;
//   load READY 2 cycles after accept, READ_DATA=0xDEADBEEF.
//  SB 0x80 @word 5 off 2, then LB -> 0xFFFFFF80; LBU -> 0x00000080; LW -> 0xDE80BEEF.
//  LH @off 1, and SW @off 2 -> READY with ERR=1, RAM word unchanged, READ_DATA=0.
//  SH 0x1234 @GPIO_WORD off 2 -> GPIO=0x12340000, RAM unchanged.
//   Then drive GPIO_IN=0xA5A5A5A5 for 3 cycles; LW @GPIO_WORD -> 0xA5A5A5A5.
//  Hold REQ high for two consecutive loads -> READY pulses exactly 3 cycles apart, each 1 cycle wide.
//  Assert RST_N=0 during RD_WAIT -> no READY after release, GPIO=0, next load completes normally.

Source files
------------

// File: rtl/risc32i_pkg.sv
// Shared constants for the RV32I data-memory responder: sizing codes, bus widths
// and the responder FSM encoding.
package risc32i_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [ADDR_W-1:0] GPIO_WORD_DEF = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: write byte enables, replicated store
// data, sign/zero-extended load data and an alignment fault flag.
module mem_lane_align
    import risc32i_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_byte_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rword,
    output logic [3:0]        o_be_c,
    output logic [DATA_W-1:0] o_wdata_c,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic              o_misalign_c
);

    logic [15:0] w_rshift;

    // Only the low half of the shifted word is ever needed for sub-word loads.
    assign w_rshift = 16'(i_rword >> {i_byte_off, 3'b000});

    always_comb begin : store_lanes
        o_be_c       = 4'h0;
        o_wdata_c    = i_wdata;
        o_misalign_c = 1'b0;
        case (i_funct3[1:0])
            2'd0: begin
                o_be_c    = 4'(4'b0001 << i_byte_off);
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                o_be_c       = 4'(4'b0011 << i_byte_off);
                o_wdata_c    = {2{i_wdata[15:0]}};
                o_misalign_c = i_byte_off[0];
            end
            2'd2: begin
                o_be_c       = 4'hF;
                o_misalign_c = |i_byte_off;
            end
            default: ;
        endcase
    end

    always_comb begin : load_extend
        o_rdata_c = '0;
        case (i_funct3)
            F3_B:    o_rdata_c = {{24{w_rshift[7]}}, w_rshift[7:0]};
            F3_H:    o_rdata_c = {{16{w_rshift[15]}}, w_rshift[15:0]};
            F3_W:    o_rdata_c = i_rword;
            F3_BU:   o_rdata_c = {24'b0, w_rshift[7:0]};
            F3_HU:   o_rdata_c = {16'b0, w_rshift[15:0]};
            default: o_rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: word RAM with byte enables plus one memory-mapped GPIO
// word, request/ready handshake with registered READY/ERR/READ_DATA.
module data_mem_responder
    import risc32i_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] GPIO_WORD   = GPIO_WORD_DEF,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ram_req,
    input  logic              i_ram_write_enable,
    input  logic [ADDR_W-1:0] i_ram_addr,
    input  logic [1:0]        i_ram_byte_off,
    input  logic [2:0]        i_ram_funct3,
    input  logic [DATA_W-1:0] i_ram_write_data,
    output logic [DATA_W-1:0] o_ram_read_data,
    output logic              o_ram_ready,
    output logic              o_ram_err,
    input  logic [DATA_W-1:0] i_gpio_in,
    output logic [DATA_W-1:0] o_gpio
);

    state_e                             r_state;
    state_e                             w_state_nxt;
    logic [DATA_W-1:0]                  r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0]                  r_rd_word;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
    logic [DATA_W-1:0]                  r_gpio;
    logic [DATA_W-1:0]                  r_read_data;
    logic                               r_ready;
    logic                               r_err;

    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata_lane;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_err;
    logic              w_is_gpio;
    logic              w_wr_ram;
    logic              w_wr_gpio;
    logic              w_rd_en;
    logic              w_ready_nxt;
    logic              w_err_nxt;
    logic [DATA_W-1:0] w_read_data_nxt;

    mem_lane_align u_align (
        .i_funct3     (i_ram_funct3),
        .i_byte_off   (i_ram_byte_off),
        .i_wdata      (i_ram_write_data),
        .i_rword      (r_rd_word),
        .o_be_c       (w_be),
        .o_wdata_c    (w_wdata_lane),
        .o_rdata_c    (w_rdata_ext),
        .o_misalign_c (w_misalign)
    );

    assign w_illegal = (i_ram_funct3 == 3'd3) || (i_ram_funct3 == 3'd6) ||
                       (i_ram_funct3 == 3'd7) ||
                       (i_ram_write_enable && (i_ram_funct3 > F3_W));
    assign w_err     = w_illegal || w_misalign;
    assign w_is_gpio = (i_ram_addr == GPIO_WORD);

    // Request fields stay stable until READY, so RD_WAIT extracts with live funct3/offset.
    always_comb begin : fsm_next
        w_state_nxt     = r_state;
        w_wr_ram        = 1'b0;
        w_wr_gpio       = 1'b0;
        w_rd_en         = 1'b0;
        w_ready_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_read_data_nxt = r_read_data;
        case (r_state)
            IDLE: begin
                if (i_ram_req) begin
                    if (w_err) begin
                        w_state_nxt     = RESP;
                        w_ready_nxt     = 1'b1;
                        w_err_nxt       = 1'b1;
                        w_read_data_nxt = '0;
                    end else if (i_ram_write_enable) begin
                        w_state_nxt     = RESP;
                        w_ready_nxt     = 1'b1;
                        w_read_data_nxt = '0;
                        w_wr_ram        = !w_is_gpio;
                        w_wr_gpio       = w_is_gpio;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_rd_en     = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                w_state_nxt     = RESP;
                w_ready_nxt     = 1'b1;
                w_read_data_nxt = w_rdata_ext;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : ctrl_regs
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_read_data <= '0;
            r_gpio      <= '0;
            r_sync      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= w_ready_nxt;
            r_err       <= w_err_nxt;
            r_read_data <= w_read_data_nxt;
            r_sync[0]   <= i_gpio_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            for (int b = 0; b < 4; b++) begin
                if (w_wr_gpio && w_be[b]) begin
                    r_gpio[b*8 +: 8] <= w_wdata_lane[b*8 +: 8];
                end
            end
        end
    end

    // RAM port kept out of the reset domain so it maps onto a byte-enabled block RAM.
    always_ff @(posedge i_clk) begin : ram_port
        for (int b = 0; b < 4; b++) begin
            if (w_wr_ram && w_be[b]) begin
                r_mem[i_ram_addr][b*8 +: 8] <= w_wdata_lane[b*8 +: 8];
            end
        end
        if (w_rd_en) begin
            r_rd_word <= w_is_gpio ? r_sync[SYNC_STAGES-1] : r_mem[i_ram_addr];
        end
    end

    assign o_ram_read_data = r_read_data;
    assign o_ram_ready     = r_ready;
    assign o_ram_err       = r_err;
    assign o_gpio          = r_gpio;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, error cases,
// GPIO path, back-to-back requests and reset during a pending load.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] gpio_in;
    logic [31:0] o_ram_read_data;
    logic        o_ram_ready;
    logic        o_ram_err;
    logic [31:0] o_gpio;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [32:0] exp_q[$];

    data_mem_responder dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_ram_req          (req),
        .i_ram_write_enable (we),
        .i_ram_addr         (addr),
        .i_ram_byte_off     (off),
        .i_ram_funct3       (f3),
        .i_ram_write_data   (wd),
        .o_ram_read_data    (o_ram_read_data),
        .o_ram_ready        (o_ram_ready),
        .o_ram_err          (o_ram_err),
        .i_gpio_in          (gpio_in),
        .o_gpio             (o_gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every READY pulse consumes one expected response.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && o_ram_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ready: got READY=1 at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("read_data", o_ram_read_data, e[31:0]);
                chk("err", {31'b0, o_ram_err}, {31'b0, e[32]});
            end
        end
    end

    task automatic do_req(input string name, input logic i_we, input logic [9:0] i_addr,
                          input logic [1:0] i_off, input logic [2:0] i_f3, input logic [31:0] i_wd,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        int   lat;
        logic seen;
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        req = 1'b1; we = i_we; addr = i_addr; off = i_off; f3 = i_f3; wd = i_wd;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_ram_ready) seen = 1'b1;
        end
        req = 1'b0;
        if (!seen) void'(exp_q.pop_back());
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int c1, c2, nrdy;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; off = '0; f3 = '0; wd = '0;
        gpio_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_read_data", o_ram_read_data, 32'h0);
        chk("rst_ready", {31'b0, o_ram_ready}, 32'h0);
        chk("rst_err", {31'b0, o_ram_err}, 32'h0);
        chk("rst_gpio", o_gpio, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("sw5",    1'b1, 10'd5, 2'd0, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        do_req("lw5",    1'b0, 10'd5, 2'd0, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, 2);
        do_req("sb5",    1'b1, 10'd5, 2'd2, 3'd0, 32'h12345680, 32'h0,        1'b0, 1);
        do_req("lb5",    1'b0, 10'd5, 2'd2, 3'd0, 32'h0,        32'hFFFFFF80, 1'b0, 2);
        do_req("lbu5",   1'b0, 10'd5, 2'd2, 3'd4, 32'h0,        32'h00000080, 1'b0, 2);
        do_req("lw5b",   1'b0, 10'd5, 2'd0, 3'd2, 32'h0,        32'hDE80BEEF, 1'b0, 2);
        do_req("lh5o2",  1'b0, 10'd5, 2'd2, 3'd1, 32'h0,        32'hFFFFDE80, 1'b0, 2);
        do_req("lhu5o0", 1'b0, 10'd5, 2'd0, 3'd5, 32'h0,        32'h0000BEEF, 1'b0, 2);
        do_req("lb5o3",  1'b0, 10'd5, 2'd3, 3'd0, 32'h0,        32'hFFFFFFDE, 1'b0, 2);
        do_req("lh_mis", 1'b0, 10'd5, 2'd1, 3'd1, 32'h0,        32'h0,        1'b1, 1);
        do_req("sw_mis", 1'b1, 10'd5, 2'd2, 3'd2, 32'h11111111, 32'h0,        1'b1, 1);
        do_req("sbu_il", 1'b1, 10'd5, 2'd0, 3'd4, 32'h22222222, 32'h0,        1'b1, 1);
        do_req("ld_f3",  1'b0, 10'd5, 2'd0, 3'd3, 32'h0,        32'h0,        1'b1, 1);
        do_req("lw5c",   1'b0, 10'd5, 2'd0, 3'd2, 32'h0,        32'hDE80BEEF, 1'b0, 2);

        do_req("sh_gpio", 1'b1, 10'h3FF, 2'd2, 3'd1, 32'h00001234, 32'h0, 1'b0, 1);
        chk("gpio_after_sh", o_gpio, 32'h12340000);
        do_req("lw5_gpio", 1'b0, 10'd5, 2'd0, 3'd2, 32'h0, 32'hDE80BEEF, 1'b0, 2);
        gpio_in = 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        do_req("lw_gpio",  1'b0, 10'h3FF, 2'd0, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0, 2);
        do_req("lbu_gpio", 1'b0, 10'h3FF, 2'd1, 3'd4, 32'h0, 32'h000000A5, 1'b0, 2);
        chk("gpio_hold", o_gpio, 32'h12340000);

        // Two loads with REQ held continuously.
        exp_q.push_back({1'b0, 32'hDE80BEEF});
        exp_q.push_back({1'b0, 32'hDE80BEEF});
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 10'd5; off = 2'd0; f3 = 3'd2;
        nrdy = 0; c1 = 0; c2 = 0;
        for (int t = 0; t < 20 && nrdy < 2; t++) begin
            @(negedge clk);
            if (o_ram_ready) begin
                if (nrdy == 0) c1 = cyc; else c2 = cyc;
                nrdy++;
            end
        end
        req = 1'b0;
        chk("b2b_count", 32'(nrdy), 32'd2);
        chk("b2b_gap", 32'(c2 - c1), 32'd3);

        // Reset while a load sits in RD_WAIT.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 10'd5; off = 2'd0; f3 = 3'd2;
        @(negedge clk);
        chk("rdwait_ready", {31'b0, o_ram_ready}, 32'h0);
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        chk("midrst_gpio", o_gpio, 32'h0);
        chk("midrst_read_data", o_ram_read_data, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", {31'b0, o_ram_ready}, 32'h0);
        chk("post_rst_gpio", o_gpio, 32'h0);
        do_req("lw_post_rst", 1'b0, 10'd5, 2'd0, 3'd2, 32'h0, 32'hDE80BEEF, 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
